spi_slave_wb: RTL



---
 rtl/spi_slave_pkg.sv | 13 +
 rtl/spi_slave_wb_if.sv | 14 +
 rtl/spi_slave_wb_sync.sv | 30 +++
 rtl/spi_slave_wb.sv | 112 +++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: register map, STATUS bit positions and SPI-side state type for spi_slave_wb
package spi_slave_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IE     = 2'd2;
    localparam logic [1:0] REG_CLR    = 2'd3;
    localparam int ST_RXV  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_UNR  = 3;
    localparam int ST_BUSY = 4;
    typedef enum logic {IDLE, SHIFT} spis_state_t;
endpackage

// File: rtl/spi_slave_wb_if.sv
// if_wb: Wishbone register-port bundle (cyc, stb, we, adr[3:2], sel, dat_i, dat_o, ack)
// slave modport: drives dat_o/ack; master modport: drives the request side
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:2]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    modport slave (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack);
endinterface

// File: rtl/spi_slave_wb_sync.sv
// spi_sync: SYNC_LEN-flop synchroniser with registered 1-cycle rise/fall strobes
// ports: clk_i, rst_i (async active-low), d (async in), q (synchronised level), rise, fall
module spi_sync #(
    parameter int   SYNC_LEN = 2,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_LEN-1:0] s;
    logic q_d;
    assign q = s[SYNC_LEN-1];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s    <= {SYNC_LEN{RST_VAL}};
            q_d  <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s    <= (s << 1) | SYNC_LEN'(d);
            q_d  <= q;
            rise <= q & ~q_d;
            fall <= ~q & q_d;
        end
    end
endmodule

// File: rtl/spi_slave_wb.sv
// spi_slave_wb: SPI mode-0 target with a Wishbone register port (DATA/STATUS/IE/CLR)
// ports: clk_i, rst_i (async active-low), bus (if_wb.slave), spi_sclk/spi_mosi/spi_ss_n (host in),
//        spi_miso (MSB first), miso_oe (pad enable while selected), interrupt (level)
module spi_slave_wb
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] FILL     = 8'hFF,
    parameter int         SYNC_LEN = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_ss_n,
    output logic spi_miso,
    output logic miso_oe,
    output logic interrupt
);
    spis_state_t state, state_n;
    logic sclk_q, sclk_rise, sclk_fall, ss_q, ss_rise, ss_fall;
    logic [SYNC_LEN-1:0] mosi_s;
    logic [7:0] shreg_rx, shreg_tx, rx_data, tx_hold, rx_byte, next_tx;
    logic [2:0] bitcnt, ie;
    logic rx_valid, tx_empty, ovr, unr, busy;
    logic acc, rd, wr, data_rd, start, s_rise, s_fall, done;
    logic [31:0] rdata;

    spi_sync #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b0)) u_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .d(spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.SYNC_LEN(SYNC_LEN), .RST_VAL(1'b1)) u_ss (
        .clk_i(clk_i), .rst_i(rst_i), .d(spi_ss_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = ss_rise ? IDLE : (ss_fall ? SHIFT : state);
        busy    = state == SHIFT;
        start   = state == IDLE && ss_fall && !ss_rise;
        s_rise  = busy && !ss_rise && sclk_rise;
        s_fall  = busy && !ss_rise && sclk_fall;
        done    = s_rise && bitcnt == 3'd7;
        rx_byte = {shreg_rx[6:0], mosi_s[SYNC_LEN-1]};
        next_tx = tx_empty ? FILL : tx_hold;
        acc     = bus.cyc && bus.stb && !bus.ack;
        rd      = acc && !bus.we;
        wr      = acc && bus.we;
        data_rd = rd && bus.adr == REG_DATA;
        rdata   = bus.adr == REG_DATA   ? {24'b0, rx_data} :
                  bus.adr == REG_STATUS ? {27'b0, busy, unr, ovr, tx_empty, rx_valid} :
                  bus.adr == REG_IE     ? {29'b0, ie} : 32'b0;
    end

    assign miso_oe   = ~ss_q;
    assign interrupt = (rx_valid & ie[0]) | (tx_empty & ie[1]) | (ovr & ie[2]);

    // Statement order matters: clears come before sets so a same-cycle set wins,
    // and the TX load precedes the DATA write so it sees the pre-write tx_hold/tx_empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.ack  <= 1'b0;
            bus.dat_o <= 32'b0;
            mosi_s   <= '0;
            spi_miso <= FILL[7];
            shreg_rx <= 8'b0;
            shreg_tx <= 8'b0;
            rx_data  <= 8'b0;
            tx_hold  <= 8'b0;
            bitcnt   <= 3'b0;
            ie       <= 3'b0;
            rx_valid <= 1'b0;
            tx_empty <= 1'b1;
            ovr      <= 1'b0;
            unr      <= 1'b0;
        end else begin
            bus.ack   <= acc;
            bus.dat_o <= rd ? rdata : 32'b0;
            mosi_s    <= (mosi_s << 1) | SYNC_LEN'(spi_mosi);
            if (ss_rise || start) bitcnt <= 3'b0;
            if (s_rise) begin
                shreg_rx <= rx_byte;
                bitcnt   <= bitcnt + 3'd1;
            end
            // bitcnt counts completed rises, so it also indexes the next bit to drive.
            if (s_fall) spi_miso <= shreg_tx[3'd7 - bitcnt];
            if (wr && bus.adr == REG_CLR && bus.dat_i[0]) ovr <= 1'b0;
            if (wr && bus.adr == REG_CLR && bus.dat_i[1]) unr <= 1'b0;
            if (start || done) begin
                shreg_tx <= next_tx;
                tx_empty <= 1'b1;
                if (tx_empty) unr <= 1'b1;
            end
            if (start) spi_miso <= next_tx[7];
            if (data_rd) rx_valid <= 1'b0;
            if (done && rx_valid && !data_rd) ovr <= 1'b1;
            if (done && (!rx_valid || data_rd)) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
            end
            if (wr && bus.adr == REG_DATA) begin
                tx_hold  <= bus.dat_i[7:0];
                tx_empty <= 1'b0;
            end
            if (wr && bus.adr == REG_IE) ie <= bus.dat_i[2:0];
        end
    end
endmodule
